// File: rtl/mem_access_ctrl_if.sv
// rtl/mem_access_ctrl_if.sv - data-memory request/acknowledge port between the MEM-stage controller and memory
interface mem_access_ctrl_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    // Controller side: issues the request, receives the completion strobe
    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_ack,
        input  mem_rdata
    );

    // Memory side
    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_ack,
        output mem_rdata
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - MEM-stage access controller with pipeline stall; optional timeout abort under MEM_TIMEOUT_EN
module mem_access_ctrl #(
    parameter int TIMEOUT = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      MemRead,
    input  logic                      MemWrite,
    input  logic [31:0]               alu_out,
    input  logic [31:0]               wdata,
    mem_access_ctrl_if.master         mem,
    output logic [31:0]               douta,
    output logic                      stall,
    output logic                      misalign,
    output logic                      bus_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;

    logic acc;
    logic ok;

    assign acc = MemRead | MemWrite;
    assign ok  = (alu_out[1:0] == 2'b00);

    // A TIMEOUT outside 1..255 cannot be represented by the 8-bit wait counter
    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
        $error("mem_access_ctrl: TIMEOUT must be in 1..255");
    end

`ifdef MEM_TIMEOUT_EN
    logic [7:0] wait_cnt;
    logic       bus_err_q;
    assign bus_err = bus_err_q;
`else
    assign bus_err = 1'b0;
`endif

    // Transaction FSM: latches the access in IDLE, holds it through REQ, gives one DONE cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            mem.mem_req   <= 1'b0;
            mem.mem_we    <= 1'b0;
            mem.mem_addr  <= 32'h0;
            mem.mem_wdata <= 32'h0;
            douta         <= 32'h0;
`ifdef MEM_TIMEOUT_EN
            wait_cnt      <= 8'h0;
            bus_err_q     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (acc && ok) begin
                        mem.mem_req   <= 1'b1;
                        // Simultaneous read and write is treated as a write
                        mem.mem_we    <= MemWrite;
                        mem.mem_addr  <= alu_out;
                        mem.mem_wdata <= wdata;
                        state         <= REQ;
`ifdef MEM_TIMEOUT_EN
                        wait_cnt      <= 8'h0;
`endif
                    end
                end
                REQ: begin
                    if (mem.mem_ack) begin
                        mem.mem_req <= 1'b0;
                        if (!mem.mem_we) begin
                            douta <= mem.mem_rdata;
                        end
                        state <= DONE;
                    end
`ifdef MEM_TIMEOUT_EN
                    // Count value c marks the (c+1)-th REQ cycle, so abort ends REQ after TIMEOUT cycles
                    else if (wait_cnt == 8'(TIMEOUT - 1)) begin
                        mem.mem_req <= 1'b0;
                        bus_err_q   <= 1'b1;
                        state       <= DONE;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
`endif
                end
                DONE: begin
                    // Inputs still belong to the retiring instruction; always return to IDLE
`ifdef MEM_TIMEOUT_EN
                    bus_err_q <= 1'b0;
`endif
                    state <= IDLE;
                end
                default: begin
                    state       <= IDLE;
                    mem.mem_req <= 1'b0;
                end
            endcase
        end
    end

    // Pipeline freeze and misalignment flag decoded from the current state
    always_comb begin
        stall    = 1'b0;
        misalign = 1'b0;
        case (state)
            IDLE: begin
                stall    = acc & ok;
                misalign = acc & ~ok;
            end
            REQ:     stall = 1'b1;
            default: stall = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - randomized self-checking bench for mem_access_ctrl
`timescale 1ns/1ps
module tb_mem_access_ctrl;

    localparam int TMO = 4;
`ifdef MEM_TIMEOUT_EN
    localparam int MAXN = TMO - 1;
`else
    localparam int MAXN = 6;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        MemRead = 1'b0;
    logic        MemWrite = 1'b0;
    logic [31:0] alu_out = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic [31:0] douta;
    logic        stall;
    logic        misalign;
    logic        bus_err;

    int errors = 0;
    int checks = 0;

    logic [31:0] exp_douta = 32'h0;

    mem_access_ctrl_if m ();

    mem_access_ctrl #(.TIMEOUT(TMO)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .MemRead  (MemRead),
        .MemWrite (MemWrite),
        .alu_out  (alu_out),
        .wdata    (wdata),
        .mem      (m.master),
        .douta    (douta),
        .stall    (stall),
        .misalign (misalign),
        .bus_err  (bus_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // One access from its IDLE cycle through DONE; enters and leaves at a negedge in IDLE.
    // The memory acks n cycles after REQ entry.
    task automatic access(input bit rd, input bit wr, input logic [31:0] addr,
                          input logic [31:0] wd, input int n, input logic [31:0] rdat);
        bit acc;
        bit ok;
        acc = rd | wr;
        ok  = (addr[1:0] == 2'b00);
        MemRead  = rd;
        MemWrite = wr;
        alu_out  = addr;
        wdata    = wd;
        #1;
        check("idle_misalign", {31'h0, misalign}, {31'h0, acc && !ok});
        check("idle_stall", {31'h0, stall}, {31'h0, acc && ok});
        if (!(acc && ok)) begin
            @(posedge clk);
            @(negedge clk);
            check("no_req", {31'h0, m.mem_req}, 32'h0);
            check("douta_hold", douta, exp_douta);
            MemRead  = 1'b0;
            MemWrite = 1'b0;
            return;
        end
        for (int i = 0; i <= n; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("req_stall", {31'h0, stall}, 32'h1);
            check("req_req", {31'h0, m.mem_req}, 32'h1);
            check("req_addr", m.mem_addr, addr);
            check("req_we", {31'h0, m.mem_we}, {31'h0, wr});
            check("req_wdata", m.mem_wdata, wd);
            check("req_misalign", {31'h0, misalign}, 32'h0);
            check("req_douta", douta, exp_douta);
            if (i == n) begin
                m.mem_ack   = 1'b1;
                m.mem_rdata = rdat;
            end else begin
                m.mem_rdata = $urandom;
            end
        end
        @(posedge clk);
        @(negedge clk);
        m.mem_ack = 1'b0;
        if (!wr) exp_douta = rdat;
        check("done_stall", {31'h0, stall}, 32'h0);
        check("done_req", {31'h0, m.mem_req}, 32'h0);
        check("done_douta", douta, exp_douta);
        check("done_buserr", {31'h0, bus_err}, 32'h0);
        // Noise in DONE must be ignored
        m.mem_ack   = 1'b1;
        m.mem_rdata = $urandom;
        MemRead     = 1'b1;
        alu_out     = {$urandom} & 32'hFFFF_FFFC;
        @(posedge clk);
        @(negedge clk);
        m.mem_ack = 1'b0;
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        #1;
        check("after_done_req", {31'h0, m.mem_req}, 32'h0);
        check("after_done_stall", {31'h0, stall}, 32'h0);
        check("after_done_douta", douta, exp_douta);
    endtask

    initial begin
        m.mem_ack   = 1'b0;
        m.mem_rdata = 32'h0;
        #12;
        check("rst_req", {31'h0, m.mem_req}, 32'h0);
        check("rst_we", {31'h0, m.mem_we}, 32'h0);
        check("rst_addr", m.mem_addr, 32'h0);
        check("rst_wdata", m.mem_wdata, 32'h0);
        check("rst_douta", douta, 32'h0);
        check("rst_stall", {31'h0, stall}, 32'h0);
        check("rst_misalign", {31'h0, misalign}, 32'h0);
        check("rst_buserr", {31'h0, bus_err}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed cases
        access(1'b1, 1'b0, 32'h0000_0040, 32'h0, 0, 32'hCAFE_F00D);
        access(1'b0, 1'b1, 32'h0000_0080, 32'h1234_5678, 3, 32'hDEAD_BEEF);
        access(1'b1, 1'b0, 32'h0000_0042, 32'h0, 0, 32'h1111_1111);
        access(1'b1, 1'b0, 32'h0000_0100, 32'h0, 0, 32'hA5A5_0001);
        access(1'b1, 1'b0, 32'h0000_0104, 32'h0, 0, 32'h5A5A_0002);
        access(1'b1, 1'b1, 32'h0000_0200, 32'h7777_7777, 1, 32'h9999_9999);

        // Randomized accesses
        for (int k = 0; k < 60; k++) begin
            logic [31:0] a;
            bit rd;
            bit wr;
            a  = $urandom;
            if ($urandom_range(3) != 0) a[1:0] = 2'b00;
            rd = 1'($urandom_range(1));
            wr = 1'($urandom_range(1));
            access(rd, wr, a, $urandom, int'($urandom_range(MAXN)), $urandom);
        end

        // Asynchronous reset in the middle of REQ
        MemRead = 1'b1;
        alu_out = 32'h0000_0300;
        @(posedge clk);
        @(negedge clk);
        MemRead = 1'b0;
        check("pre_rst_req", {31'h0, m.mem_req}, 32'h1);
        #2;
        rst_n = 1'b0;
        exp_douta = 32'h0;
        #1;
        check("arst_req", {31'h0, m.mem_req}, 32'h0);
        check("arst_douta", douta, 32'h0);
        check("arst_stall", {31'h0, stall}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("post_rst_stall", {31'h0, stall}, 32'h0);
        check("post_rst_req", {31'h0, m.mem_req}, 32'h0);

`ifdef MEM_TIMEOUT_EN
        // Load that never gets acked: TMO REQ cycles, then a DONE with bus_err
        MemRead = 1'b1;
        alu_out = 32'h0000_0400;
        #1;
        check("tmo_idle_stall", {31'h0, stall}, 32'h1);
        for (int i = 0; i < TMO; i++) begin
            @(posedge clk);
            @(negedge clk);
            MemRead = 1'b0;
            check("tmo_req", {31'h0, m.mem_req}, 32'h1);
            check("tmo_stall", {31'h0, stall}, 32'h1);
            check("tmo_buserr_low", {31'h0, bus_err}, 32'h0);
        end
        @(posedge clk);
        @(negedge clk);
        check("tmo_done_req", {31'h0, m.mem_req}, 32'h0);
        check("tmo_done_buserr", {31'h0, bus_err}, 32'h1);
        check("tmo_done_stall", {31'h0, stall}, 32'h0);
        check("tmo_done_douta", douta, exp_douta);
        @(posedge clk);
        @(negedge clk);
        check("tmo_after_buserr", {31'h0, bus_err}, 32'h0);
        // Ack on the last allowed cycle completes normally
        access(1'b1, 1'b0, 32'h0000_0404, 32'h0, TMO - 1, 32'h0BAD_CAFE);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
